// File: rtl/dac_tx_pkg.sv
// Shared types, constants and the sample-to-code helper for the interleaved DAC transmitter.
package dac_tx_pkg;

  typedef logic [13:0]        dac_word_t;
  typedef logic signed [15:0] smp_t;

  localparam dac_word_t MIDSCALE = 14'h2000;

  typedef enum logic [1:0] {
    StOff,
    StReset,
    StPrime,
    StRun
  } dac_tx_st_t;

  // Clamp a signed 16-bit sample to the 14-bit range, then flip the sign bit for offset binary.
  function automatic dac_word_t sat14_ob(input smp_t s);
    smp_t c;
    if (s > 16'sd8191) begin
      c = 16'sd8191;
    end else if (s < -16'sd8192) begin
      c = -16'sd8192;
    end else begin
      c = s;
    end
    return {~c[13], c[12:0]};
  endfunction

endpackage

// File: rtl/dac_tx_fifo.sv
// Synchronous first-word-fall-through FIFO for sample pairs.
// Pointers carry one extra MSB so full and empty are distinguishable.
module dac_tx_fifo
  import dac_tx_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = 2
) (
  input  logic             clk0,
  input  logic             rstn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AddrW:0]   cnt_o
);

  localparam int unsigned Depth = 1 << AddrW;
  localparam logic [AddrW:0] PtrOne = (AddrW + 1)'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign cnt_o   = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  // Overflow and underflow attempts are ignored so stored data is never overwritten.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk0) begin
    if (do_push) begin
      mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
    end
  end

  // Read/write pointers with synchronous reset and flush.
  always_ff @(posedge clk0) begin
    if (!rstn || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

endmodule

// File: rtl/dac_intlv_tx.sv
// Interleaved single-bus DAC transmitter: buffers signed A/B sample pairs and drives one
// offset-binary word per clk0, alternating channels (dac_sel_o: 0=A, 1=B).
// Optional build macro DAC_TX_PATTERN_EN adds pat_en_i and an internal ramp test pattern.
module dac_intlv_tx
  import dac_tx_pkg::*;
#(
  parameter int unsigned FIFO_AW   = 2,
  parameter int unsigned PRIME_LVL = 2,
  parameter int unsigned RST_CYC   = 16,
  parameter int unsigned INV       = 0
) (
  input  logic             clk0,
  input  logic             rstn,
  input  logic             en_i,
`ifdef DAC_TX_PATTERN_EN
  input  logic             pat_en_i,
`endif
  input  logic [1:0][15:0] s_dat_i,
  input  logic             s_vld_i,
  output logic             s_rdy_o,
  output logic [13:0]      dac_dat_o,
  output logic             dac_sel_o,
  output logic             dac_wrt_o,
  output logic             dac_rst_o,
  output logic             underrun_o,
  output logic [15:0]      urun_cnt_o
);

  localparam int unsigned    Depth   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] CntOne  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0] CntFull = (FIFO_AW + 1)'(Depth);
  localparam logic [15:0]    RstLast = 16'(RST_CYC - 1);
  localparam dac_word_t      InvMask = (INV != 0) ? 14'h3FFF : 14'h0000;

  dac_tx_st_t     state_q;
  logic           phase_q;
  logic [15:0]    rst_cnt_q;
  logic           rst_q;
  logic [31:0]    hold_q;
  dac_word_t      dat_q;
  logic           sel_q, wrt_q, rdy_q;
  logic           underrun_q;
  logic [15:0]    urun_cnt_q;

  logic [31:0]    fifo_rdata;
  logic           fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_cnt, cnt_nxt;
  logic           push, pop, urun, slot, flush;
  dac_word_t      word_a, word_b;

  function automatic dac_word_t enc(input logic [15:0] v);
    return sat14_ob(smp_t'(v)) ^ InvMask;
  endfunction

  assign push  = s_vld_i && rdy_q;
  assign flush = (state_q == StOff);
  // A pair slot is the phase-0 cycle of RUN while still enabled.
  assign slot  = (state_q == StRun) && !phase_q && en_i;

`ifdef DAC_TX_PATTERN_EN
  dac_word_t ramp_q;

  assign pop  = slot && !pat_en_i && !fifo_empty;
  assign urun = slot && !pat_en_i && fifo_empty;

  // Test ramp: advances once per transmitted pair, restarts from zero whenever idle.
  always_ff @(posedge clk0) begin
    if (!rstn || state_q == StOff) begin
      ramp_q <= '0;
    end else if (state_q == StRun && phase_q && pat_en_i) begin
      ramp_q <= ramp_q + 14'd1;
    end
  end
`else
  assign pop  = slot && !fifo_empty;
  assign urun = slot && fifo_empty;
`endif

  // On a pop the A word comes straight from the FIFO head; otherwise the held pair repeats.
  always_comb begin
    word_a = enc(pop ? fifo_rdata[15:0] : hold_q[15:0]);
    word_b = enc(hold_q[31:16]);
`ifdef DAC_TX_PATTERN_EN
    if (pat_en_i) begin
      word_a = ramp_q;
      word_b = ~ramp_q;
    end
`endif
  end

  // Predicted occupancy after this edge, so s_rdy_o can be registered yet exact.
  always_comb begin
    cnt_nxt = fifo_cnt;
    if (flush) begin
      cnt_nxt = '0;
    end else if (push && !pop) begin
      cnt_nxt = fifo_cnt + CntOne;
    end else if (pop && !push) begin
      cnt_nxt = fifo_cnt - CntOne;
    end
  end

  // Ready register: en_i=0 always leads to OFF next, so it gates readiness directly.
  always_ff @(posedge clk0) begin
    if (!rstn) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= en_i && (cnt_nxt != CntFull);
    end
  end

  dac_tx_fifo #(
    .Width (32),
    .AddrW (FIFO_AW)
  ) u_fifo (
    .clk0    (clk0),
    .rstn    (rstn),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (s_dat_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  // Sequencer with registered DAC bus, reset pulse and underrun bookkeeping.
  always_ff @(posedge clk0) begin
    if (!rstn) begin
      state_q    <= StOff;
      phase_q    <= 1'b0;
      rst_cnt_q  <= '0;
      rst_q      <= 1'b0;
      hold_q     <= '0;
      dat_q      <= MIDSCALE;
      sel_q      <= 1'b0;
      wrt_q      <= 1'b0;
      underrun_q <= 1'b0;
      urun_cnt_q <= '0;
    end else begin
      dat_q <= MIDSCALE;
      sel_q <= 1'b0;
      wrt_q <= 1'b0;
      unique case (state_q)
        StOff: begin
          underrun_q <= 1'b0;
          urun_cnt_q <= '0;
          if (en_i) begin
            state_q   <= StReset;
            rst_q     <= 1'b1;
            rst_cnt_q <= '0;
          end
        end
        StReset: begin
          if (!en_i) begin
            state_q <= StOff;
            rst_q   <= 1'b0;
          end else if (rst_cnt_q == RstLast) begin
            state_q <= StPrime;
            rst_q   <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 16'd1;
          end
        end
        StPrime: begin
          if (!en_i) begin
            state_q <= StOff;
          end else if (32'(fifo_cnt) >= PRIME_LVL) begin
            state_q <= StRun;
            phase_q <= 1'b0;
          end
        end
        StRun: begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            // B of the previous pair is on the bus now, so disabling here loses nothing.
            if (!en_i) begin
              state_q    <= StOff;
              underrun_q <= 1'b0;
              urun_cnt_q <= '0;
            end else begin
              wrt_q <= 1'b1;
              dat_q <= word_a;
              if (pop) begin
                hold_q <= fifo_rdata;
              end
              if (urun) begin
                underrun_q <= 1'b1;
                if (urun_cnt_q != 16'hFFFF) urun_cnt_q <= urun_cnt_q + 16'd1;
              end
            end
          end else begin
            wrt_q <= 1'b1;
            sel_q <= 1'b1;
            dat_q <= word_b;
            if (!en_i) begin
              state_q    <= StOff;
              underrun_q <= 1'b0;
              urun_cnt_q <= '0;
            end
          end
        end
        default: state_q <= StOff;
      endcase
    end
  end

  assign s_rdy_o    = rdy_q;
  assign dac_dat_o  = dat_q;
  assign dac_sel_o  = sel_q;
  assign dac_wrt_o  = wrt_q;
  assign dac_rst_o  = rst_q;
  assign underrun_o = underrun_q;
  assign urun_cnt_o = urun_cnt_q;

  // Full is implied by the occupancy count; the flag is kept for observability only.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_dac_intlv_tx.sv
// Scoreboard bench for dac_intlv_tx: stimulus queues expected {sel, word} pairs, a monitor
// pops and compares on every dac_wrt_o cycle. Pattern test runs only with DAC_TX_PATTERN_EN.
module tb_dac_intlv_tx;

  logic             clk0 = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0;
  logic             pat_en = 1'b0;
  logic [1:0][15:0] s_dat = '0;
  logic             s_vld = 1'b0;
  logic             s_rdy_o;
  logic [13:0]      dac_dat_o;
  logic             dac_sel_o, dac_wrt_o, dac_rst_o, underrun_o;
  logic [15:0]      urun_cnt_o;

  logic [14:0] exp_q[$];
  logic [14:0] mon_e;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk0 = ~clk0;

  dac_intlv_tx #(
    .FIFO_AW   (2),
    .PRIME_LVL (2),
    .RST_CYC   (16),
    .INV       (0)
  ) dut (
    .clk0       (clk0),
    .rstn       (rstn),
    .en_i       (en),
`ifdef DAC_TX_PATTERN_EN
    .pat_en_i   (pat_en),
`endif
    .s_dat_i    (s_dat),
    .s_vld_i    (s_vld),
    .s_rdy_o    (s_rdy_o),
    .dac_dat_o  (dac_dat_o),
    .dac_sel_o  (dac_sel_o),
    .dac_wrt_o  (dac_wrt_o),
    .dac_rst_o  (dac_rst_o),
    .underrun_o (underrun_o),
    .urun_cnt_o (urun_cnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every written word must match the head of the scoreboard.
  always @(negedge clk0) begin
    if (dac_wrt_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_word: got sel=%0d dat=%h, required no write", dac_sel_o,
                 dac_dat_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("dac_word", {17'b0, dac_sel_o, dac_dat_o}, {17'b0, mon_e});
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk0);
      #1;
    end
  endtask

  // Offer one pair, wait (bounded) for ready, optionally queue its expected A/B words.
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [13:0] ea,
                      input logic [13:0] eb, input bit want);
    int n = 0;
    s_dat = {b, a};
    s_vld = 1'b1;
    if (want) begin
      exp_q.push_back({1'b0, ea});
      exp_q.push_back({1'b1, eb});
    end
    while (!s_rdy_o && n < 200) begin
      cyc(1);
      n++;
    end
    if (!s_rdy_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: got s_rdy_o=0, required 1");
    end
    cyc(1);
    s_vld = 1'b0;
  endtask

  task automatic wait_q(input int n, input int lim);
    int k = 0;
    while (exp_q.size() != n && k < lim) begin
      @(negedge clk0);
      #1;
      k++;
    end
    if (exp_q.size() != n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_queue: got size %0d, required %0d", exp_q.size(), n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_hi;
    bit mid_bad;

    // Reset state.
    cyc(3);
    check("rst_dat", 32'(dac_dat_o), 32'h2000);
    check("rst_sel", 32'(dac_sel_o), 0);
    check("rst_wrt", 32'(dac_wrt_o), 0);
    check("rst_dacrst", 32'(dac_rst_o), 0);
    check("rst_rdy", 32'(s_rdy_o), 0);
    check("rst_urun", 32'(underrun_o), 0);
    check("rst_urun_cnt", 32'(urun_cnt_o), 0);
    rstn = 1'b1;
    cyc(2);

    // Enable: DAC reset pulse length, bus idle at midscale.
    en = 1'b1;
    rst_hi = 0;
    mid_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk0);
      if (dac_rst_o) rst_hi++;
      if (dac_dat_o != 14'h2000) mid_bad = 1'b1;
    end
    #1;
    check("dac_rst_cycles", 32'(rst_hi), 16);
    check("mid_during_reset", 32'(mid_bad), 0);
    check("rdy_in_prime", 32'(s_rdy_o), 1);

    // Conversion, then underrun repeats of the last pair.
    push(16'h0000, 16'hFFFF, 14'h2000, 14'h1FFF, 1'b1);
    push(16'h7FFF, 16'h8000, 14'h3FFF, 14'h0000, 1'b1);
    push(16'd100,  16'hFF9C, 14'h2064, 14'h1F9C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 14'h2064});
      exp_q.push_back({1'b1, 14'h1F9C});
    end
    wait_q(1, 200);
    check("underrun_set", 32'(underrun_o), 1);
    check("urun_cnt_3", 32'(urun_cnt_o), 3);

    // Disable on an A word: B follows, then idle with cleared flags.
    en = 1'b0;
    cyc(2);
    check("off_wrt", 32'(dac_wrt_o), 0);
    check("off_dat", 32'(dac_dat_o), 32'h2000);
    check("off_urun", 32'(underrun_o), 0);
    check("off_urun_cnt", 32'(urun_cnt_o), 0);
    check("off_rdy", 32'(s_rdy_o), 0);
    check("off_queue", 32'(exp_q.size()), 0);
    cyc(3);

    // Fill during the DAC reset window (no pops): ready drops after four pairs.
    en = 1'b1;
    push(16'h1FFF, 16'hE000, 14'h3FFF, 14'h0000, 1'b1);
    push(16'h2000, 16'hDFFF, 14'h3FFF, 14'h0000, 1'b1);
    push(16'h0001, 16'hFFFE, 14'h2001, 14'h1FFE, 1'b1);
    push(16'h1000, 16'hF000, 14'h3000, 14'h1000, 1'b1);
    check("full_rdy_low", 32'(s_rdy_o), 0);
    cyc(3);
    check("full_rdy_held", 32'(s_rdy_o), 0);
    check("full_in_reset", 32'(dac_rst_o), 1);
    push(16'hE001, 16'h1FFE, 14'h0001, 14'h3FFE, 1'b1);
    wait_q(1, 300);
    check("no_underrun", 32'(underrun_o), 0);
    en = 1'b0;
    cyc(2);
    check("off2_wrt", 32'(dac_wrt_o), 0);
    check("off2_dat", 32'(dac_dat_o), 32'h2000);
    cyc(3);

`ifdef DAC_TX_PATTERN_EN
    // Ramp pattern through the 3FFF -> 0000 wrap; FIFO stays untouched.
    en = 1'b1;
    pat_en = 1'b1;
    push(16'h0000, 16'h0000, 14'h0, 14'h0, 1'b0);
    push(16'h0000, 16'h0000, 14'h0, 14'h0, 1'b0);
    for (int k = 0; k < 16386; k++) begin
      logic [13:0] r;
      r = k[13:0];
      exp_q.push_back({1'b0, r});
      exp_q.push_back({1'b1, ~r});
    end
    wait_q(1, 40000);
    check("pat_no_underrun", 32'(underrun_o), 0);
    en = 1'b0;
    cyc(2);
    pat_en = 1'b0;
    check("pat_off_wrt", 32'(dac_wrt_o), 0);
`endif

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
